alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Clocked initiator for the register-bank/ALU datapath: it replaces hand-driven address and selector stimulus with a micro-sequencer.
- Fetches 32-bit op words from a synchronous program ROM and decodes the source, destination and ALU-select fields.
- Drives the read/write register addresses and ALU selector, then issues a single-cycle regWrite strobe per op.
- Sits between program memory and the combinational datapath; the datapath's register bank must commit writeData only while regWrite is high.

Parameters:
- PROG_LEN, 16, number of op words in a program run; range 1..2**ADDR_W.
- ADDR_W, 5, program-ROM address width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin a program run at address 0; sampled only in IDLE.
- instr_addr  output  ADDR_W  ROM address (pc).
- instr_data  input  32  ROM data; valid one cycle after instr_addr is presented.
- read_reg1  output  5  datapath readReg1 (rs).
- read_reg2  output  5  datapath readReg2 (rt).
- write_reg  output  5  datapath writeReg (rd).
- alu_sel  output  3  datapath ALU selector.
- reg_write  output  1  write strobe; high exactly one cycle per committed op.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a run ends.
- op_count  output  ADDR_W+1  ops committed in the current/last run.
- err_count  output  ADDR_W+1  illegal ops skipped in the current/last run.

Behaviour:
- Op word fields:
  - [31:29] op: 0 add, 1 sub, 2 set-greater, 3 and, 4 or, 5 xor, 6 illegal, 7 halt.
  - [28:24] rs, [23:19] rt, [18:14] rd.
  - [13:0] ignored.
- Reset (rst_n low at a clock edge, including mid-run):
  - state = IDLE.
  - pc, read_reg1, read_reg2, write_reg and alu_sel = 0.
  - reg_write, busy and done = 0.
  - op_count and err_count = 0.
- States: IDLE, FETCH, WAIT, DECODE, EXEC, WB, DONE.
- IDLE:
  - start=1 -> FETCH; pc=0, op_count=0, err_count=0.
  - Otherwise remain in IDLE. Counters hold their last-run values.
- FETCH: instr_addr=pc -> WAIT.
- WAIT: ROM latency cycle -> DECODE.
- DECODE: register the instr_data fields.
  - op=7 -> DONE; no write, counters unchanged.
  - Otherwise -> EXEC.
- EXEC:
  - Present read_reg1=rs, read_reg2=rt, write_reg=rd, alu_sel=op[2:0].
  - reg_write=0; this cycle lets the combinational datapath settle. -> WB.
- WB:
  - op<=5: reg_write=1 for this cycle only, op_count+1.
  - op=6: reg_write=0, err_count+1.
  - Addresses and alu_sel hold their EXEC values through WB.
  - Then: if pc==PROG_LEN-1 -> DONE; else pc+1 -> FETCH.
- DONE: done=1 for one cycle, busy=1 -> IDLE.
- Output holding:
  - Addresses and alu_sel hold their last values outside EXEC/WB.
  - instr_addr always equals pc.
- Throughput: 5 cycles per non-halt op; start-to-done latency = 5*N+1 cycles for N ops without halt.
- Boundaries:
  - start held high or pulsed while busy is ignored; re-asserting start in the DONE cycle is ignored.
  - A new run needs start in IDLE. A start held continuously re-launches on the first IDLE cycle.
  - pc never wraps: the end test precedes the increment.
  - PROG_LEN=1 runs exactly one op.
  - Halt at address 0 gives done 4 cycles after start, with op_count=0.
  - rd=0 is written like any other register (no hardwired zero).
  - Counters saturate only by construction: max PROG_LEN fits ADDR_W+1 bits.

Test Plan:
- Reset mid-run: reset asserted during the EXEC of the 3rd op -> next cycle state=IDLE; all outputs 0; no reg_write pulse; start afterwards runs from pc=0.
- Single add: PROG_LEN=1, word op=0 rs=13 rt=10 rd=8, start -> at cycle 4 read_reg1=13, read_reg2=10, write_reg=8, alu_sel=0 with reg_write=1 (in WB); done at cycle 5; op_count=1.
- Full six-op program (sel 0..5, addresses 13/10/8, 12/9/1, 11/8/5, 10/7/6, 19/6/9, 18/5/3), PROG_LEN=6:
  - exactly 6 reg_write pulses, 5 cycles apart, each carrying the listed addresses;
  - done at cycle 30; op_count=6, err_count=0.
- Illegal op: word op=6 rs=17 rt=4 rd=18 placed between two legal ops, PROG_LEN=3 -> no reg_write for it; err_count=1, op_count=2.
- Halt: op=7 at address 2 with PROG_LEN=16 -> two writes, then done; pc never reaches 3; busy low the cycle after done.
- start re-pulsed during busy -> ignored; no restart; pc sequence monotonic.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Micro-sequencer that fetches op words from a synchronous program ROM and drives
// register-bank addresses, ALU select and a single-cycle write strobe per op.
module alu_op_sequencer #(
    parameter int PROG_LEN = 16,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [31:0]       instr_data,
    output logic [4:0]        read_reg1,
    output logic [4:0]        read_reg2,
    output logic [4:0]        write_reg,
    output logic [2:0]        alu_sel,
    output logic              reg_write,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   op_count,
    output logic [ADDR_W:0]   err_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        DECODE,
        EXEC,
        WB,
        DONE
    } state_t;

    localparam logic [2:0]        OP_ILLEGAL = 3'd6;
    localparam logic [2:0]        OP_HALT    = 3'd7;
    localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(PROG_LEN - 1);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        op_q;

    logic [2:0] op_field;
    logic [4:0] rs_field;
    logic [4:0] rt_field;
    logic [4:0] rd_field;
    logic       unused_low_bits;

    assign op_field        = instr_data[31:29];
    assign rs_field        = instr_data[28:24];
    assign rt_field        = instr_data[23:19];
    assign rd_field        = instr_data[18:14];
    assign unused_low_bits = ^instr_data[13:0];

    assign instr_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            op_q      <= '0;
            read_reg1 <= '0;
            read_reg2 <= '0;
            write_reg <= '0;
            alu_sel   <= '0;
            op_count  <= '0;
            err_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        pc        <= '0;
                        op_count  <= '0;
                        err_count <= '0;
                    end
                end
                DECODE: begin
                    // A halt leaves the previously presented addresses untouched.
                    if (op_field != OP_HALT) begin
                        op_q      <= op_field;
                        read_reg1 <= rs_field;
                        read_reg2 <= rt_field;
                        write_reg <= rd_field;
                        alu_sel   <= op_field;
                    end
                end
                WB: begin
                    if (op_q == OP_ILLEGAL) begin
                        err_count <= err_count + CNT_ONE;
                    end else begin
                        op_count <= op_count + CNT_ONE;
                    end
                    // End test precedes the increment so pc never wraps.
                    if (pc != LAST_PC) begin
                        pc <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        reg_write  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = FETCH;
            end
            FETCH:  state_next = WAIT;
            WAIT:   state_next = DECODE;
            DECODE: state_next = (op_field == OP_HALT) ? DONE : EXEC;
            EXEC:   state_next = WB;
            WB: begin
                reg_write  = (op_q != OP_ILLEGAL);
                state_next = (pc == LAST_PC) ? DONE : FETCH;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer: a program-level reference model
// predicts every write strobe, its timing, the done cycle and the final counters.
module tb_alu_op_sequencer;

    localparam int PLEN = 6;
    localparam int AW   = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] instr_addr;
    logic [31:0]   instr_data;
    logic [4:0]    read_reg1;
    logic [4:0]    read_reg2;
    logic [4:0]    write_reg;
    logic [2:0]    alu_sel;
    logic          reg_write;
    logic          busy;
    logic          done;
    logic [AW:0]   op_count;
    logic [AW:0]   err_count;

    logic [31:0] rom [0:(1<<AW)-1];

    typedef struct {
        int         cyc;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [2:0] sel;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];

    int checks = 0;
    int errors = 0;

    alu_op_sequencer #(.PROG_LEN(PLEN), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .alu_sel    (alu_sel),
        .reg_write  (reg_write),
        .busy       (busy),
        .done       (done),
        .op_count   (op_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: data valid one cycle after the address.
    always @(posedge clk) instr_data <= rom[instr_addr];

    function automatic logic [31:0] mkword(input int op, input int rs, input int rt, input int rd);
        return {3'(op), 5'(rs), 5'(rt), 5'(rd), 14'($urandom)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fillRandom(input int from);
        for (int i = from; i < (1 << AW); i++) rom[i] = $urandom;
    endtask

    task automatic loadSixOps();
        rom[0] = mkword(0, 13, 10, 8);
        rom[1] = mkword(1, 12, 9, 1);
        rom[2] = mkword(2, 11, 8, 5);
        rom[3] = mkword(3, 10, 7, 6);
        rom[4] = mkword(4, 19, 6, 9);
        rom[5] = mkword(5, 18, 5, 3);
        fillRandom(PLEN);
    endtask

    // Cycle offsets are counted in clock edges after the edge that samples start.
    task automatic applyStimulus(input bit noisy);
        wr_t           e;
        wr_t           o;
        int            exp_done;
        int            exp_ops;
        int            exp_errs;
        int            last_pc;
        int            done_at;
        int            max_pc;
        int            n;
        bit            mono_ok;
        bit            busy_ok;
        logic [AW-1:0] prev;

        exp_q.delete();
        obs_q.delete();
        exp_ops  = 0;
        exp_errs = 0;
        exp_done = -1;
        last_pc  = 0;
        for (int i = 0; i < PLEN; i++) begin
            last_pc = i;
            if (rom[i][31:29] == 3'd7) begin
                exp_done = 5 * i + 3;
                break;
            end
            if (rom[i][31:29] == 3'd6) begin
                exp_errs++;
            end else begin
                e.cyc = 5 * i + 4;
                e.rs  = rom[i][28:24];
                e.rt  = rom[i][23:19];
                e.rd  = rom[i][18:14];
                e.sel = rom[i][31:29];
                exp_q.push_back(e);
                exp_ops++;
            end
        end
        if (exp_done < 0) exp_done = 5 * PLEN;

        @(negedge clk);
        start   = 1'b1;
        done_at = -1;
        max_pc  = 0;
        prev    = '0;
        mono_ok = 1'b1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 5 * PLEN + 10; k++) begin
            @(negedge clk);
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (reg_write) begin
                o.cyc = k - 1;
                o.rs  = read_reg1;
                o.rt  = read_reg2;
                o.rd  = write_reg;
                o.sel = alu_sel;
                obs_q.push_back(o);
            end
            if (instr_addr < prev) mono_ok = 1'b0;
            if (int'(instr_addr) > max_pc) max_pc = int'(instr_addr);
            prev = instr_addr;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                done_at = k - 1;
                start   = 1'b0;
                break;
            end
        end

        checkOutput("done_cycle", done_at, exp_done);
        checkOutput("write_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput("write_cycle", obs_q[i].cyc, exp_q[i].cyc);
            checkOutput("write_rs", obs_q[i].rs, exp_q[i].rs);
            checkOutput("write_rt", obs_q[i].rt, exp_q[i].rt);
            checkOutput("write_rd", obs_q[i].rd, exp_q[i].rd);
            checkOutput("write_sel", obs_q[i].sel, exp_q[i].sel);
        end
        checkOutput("pc_monotonic", mono_ok, 1);
        checkOutput("pc_max", max_pc, last_pc);
        checkOutput("busy_in_run", busy_ok, 1);

        @(negedge clk);
        checkOutput("busy_after", busy, 0);
        checkOutput("done_after", done, 0);
        checkOutput("op_count", op_count, exp_ops);
        checkOutput("err_count", err_count, exp_errs);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_reg_write"}, reg_write, 0);
        checkOutput({tag, "_instr_addr"}, instr_addr, 0);
        checkOutput({tag, "_rr1"}, read_reg1, 0);
        checkOutput({tag, "_rr2"}, read_reg2, 0);
        checkOutput({tag, "_wr"}, write_reg, 0);
        checkOutput({tag, "_alu_sel"}, alu_sel, 0);
        checkOutput({tag, "_op_count"}, op_count, 0);
        checkOutput({tag, "_err_count"}, err_count, 0);
    endtask

    initial begin
        int r;
        int op;

        rst_n = 1'b0;
        start = 1'b0;
        fillRandom(0);
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] six-op program");
        loadSixOps();
        applyStimulus(1'b0);

        $display("[TB] single add then halt");
        rom[0] = mkword(0, 13, 10, 8);
        rom[1] = mkword(7, 0, 0, 0);
        applyStimulus(1'b0);

        $display("[TB] illegal op between legal ops");
        rom[0] = mkword(0, 3, 4, 7);
        rom[1] = mkword(6, 17, 4, 18);
        rom[2] = mkword(4, 21, 22, 23);
        rom[3] = mkword(7, 0, 0, 0);
        applyStimulus(1'b0);

        $display("[TB] halt at address 2 with start noise");
        rom[0] = mkword(1, 1, 2, 3);
        rom[1] = mkword(5, 4, 5, 6);
        rom[2] = mkword(7, 9, 9, 9);
        applyStimulus(1'b1);

        $display("[TB] halt at address 0");
        rom[0] = mkword(7, 31, 31, 31);
        applyStimulus(1'b0);

        $display("[TB] write to rd=0");
        rom[0] = mkword(5, 1, 2, 0);
        rom[1] = mkword(2, 0, 0, 0);
        rom[2] = mkword(7, 0, 0, 0);
        applyStimulus(1'b0);

        $display("[TB] reset during EXEC of third op");
        loadSixOps();
        @(negedge clk);
        start = 1'b1;
        repeat (14) begin
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("exec3_write_reg", write_reg, 5);
        checkOutput("exec3_read_reg1", read_reg1, 11);
        checkOutput("exec3_reg_write", reg_write, 0);
        rst_n = 1'b0;
        @(negedge clk);
        checkAllZero("midrun_reset");
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0);

        $display("[TB] randomized programs");
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < PLEN; i++) begin
                r = $urandom_range(0, 15);
                if (r == 0)      op = 7;
                else if (r < 3)  op = 6;
                else             op = $urandom_range(0, 5);
                rom[i] = mkword(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
            end
            applyStimulus(1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
